// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin sharing of one external combinational 8-bit ALU among NREQ requesters
// Ports: clk/reset (sync, active-high); req_valid/req_ready + packed req_a/req_b/req_op per requester;
// alu_a/alu_b/alu_op registered operands to the ALU, alu_res/alu_z/alu_c back from it;
// resp_valid/resp_ready response handshake carrying resp_id/resp_out/resp_zero/resp_carry/resp_err.
module alu_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [4*NREQ-1:0] req_op,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_op,
  input  logic [7:0]        alu_res,
  input  logic              alu_z,
  input  logic              alu_c,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [7:0]        resp_out,
  output logic              resp_zero,
  output logic              resp_carry,
  output logic              resp_err
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [IDW-1:0] last_grant, grant, idx;
  logic found;
  // first pending requester strictly after last_grant, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    grant = last_grant;
    idx = last_grant;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_grant) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end
  assign req_ready = (state == IDLE && found) ? NREQ'(1) << grant : '0;
  assign resp_valid = state == RESP;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      resp_id <= '0;
      resp_out <= '0;
      resp_zero <= 1'b0;
      resp_carry <= 1'b0;
      resp_err <= 1'b0;
    end else if (state == IDLE && found) begin
      alu_a <= req_a[8*grant +: 8];
      alu_b <= req_b[8*grant +: 8];
      alu_op <= req_op[4*grant +: 4];
      last_grant <= grant;
      resp_id <= grant;
      state <= EXEC;
    end else if (state == EXEC) begin
      resp_out <= alu_res;
      resp_zero <= alu_z;
      resp_carry <= alu_c;
      resp_err <= alu_op == 4'h0 || alu_op > 4'hB;
      state <= RESP;
    end else if (state == RESP && resp_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: randomized and directed checks of alu_scheduler against a transaction-level model
module tb_alu_scheduler;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [8*NREQ-1:0] req_a, req_b;
  logic [4*NREQ-1:0] req_op;
  logic [7:0] alu_a, alu_b, alu_res, resp_out;
  logic [3:0] alu_op;
  logic alu_z, alu_c, resp_valid, resp_ready, resp_zero, resp_carry, resp_err;
  logic [IDW-1:0] resp_id;
  typedef struct {
    logic [IDW-1:0] id;
    logic [9:0] r;
    logic err;
  } item_t;
  item_t q[$];
  bit busy;
  int wait_c, last, n_cmp, n_bad;
  logic [NREQ-1:0] acc_mask;
  always #5 clk = ~clk;
  alu_scheduler #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_z(alu_z), .alu_c(alu_c),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_out(resp_out), .resp_zero(resp_zero), .resp_carry(resp_carry), .resp_err(resp_err)
  );
  // external ALU: returns {carry, zero, result}
  function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [8:0] t;
    t = '0;
    case (op)
      4'h1: t = {1'b0, a} + {1'b0, b};
      4'h2: t = {1'b0, a} - {1'b0, b};
      4'h3: t = {1'b0, a & b};
      4'h4: t = {1'b0, a | b};
      4'h5: t = {1'b0, a ^ b};
      4'h6: t = {1'b0, ~a};
      4'h7: t = {a, 1'b0};
      4'h8: t = {a[0], 1'b0, a[7:1]};
      4'h9: t = {1'b0, a} + 9'd1;
      4'hA: t = {1'b0, a} - 9'd1;
      4'hB: t = {1'b0, b};
      default: t = '0;
    endcase
    return {t[8], t[7:0] == 8'h00, t[7:0]};
  endfunction
  assign {alu_c, alu_z, alu_res} = alu_fn(alu_a, alu_b, alu_op);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // one cycle of the reference model: predict, compare, then advance the model past the edge
  task automatic eval();
    logic [NREQ-1:0] er;
    int g, j;
    bit was_busy, ev;
    item_t it;
    acc_mask = '0;
    if (reset) begin
      busy = 0;
      wait_c = 0;
      last = NREQ - 1;
      q.delete();
      return;
    end
    er = '0;
    g = -1;
    if (!busy)
      for (int k = 1; k <= NREQ; k++) begin
        j = (last + k) % NREQ;
        if (g < 0 && req_valid[IDW'(j)]) g = j;
      end
    if (g >= 0) er[IDW'(g)] = 1'b1;
    ev = busy && wait_c == 0;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("resp_valid", 32'(resp_valid), 32'(ev));
    if (ev) begin
      chk("resp_id", 32'(resp_id), 32'(q[0].id));
      chk("resp_out", 32'(resp_out), 32'(q[0].r[7:0]));
      chk("resp_zero", 32'(resp_zero), 32'(q[0].r[8]));
      chk("resp_carry", 32'(resp_carry), 32'(q[0].r[9]));
      chk("resp_err", 32'(resp_err), 32'(q[0].err));
    end
    was_busy = busy;
    if (ev && resp_ready) begin
      void'(q.pop_front());
      busy = 0;
    end
    if (!was_busy && g >= 0) begin
      it.id = IDW'(g);
      it.r = alu_fn(req_a[8*g +: 8], req_b[8*g +: 8], req_op[4*g +: 4]);
      it.err = req_op[4*g +: 4] == 4'h0 || req_op[4*g +: 4] > 4'hB;
      q.push_back(it);
      last = g;
      busy = 1;
      wait_c = 2;
      acc_mask[IDW'(g)] = 1'b1;
    end
    if (busy && wait_c > 0) wait_c--;
  endtask
  task automatic sample();
    @(negedge clk);
  endtask
  task automatic advance();
    eval();
    @(posedge clk);
    #1;
  endtask
  task automatic step();
    sample();
    advance();
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_alu"}, 32'({alu_a, alu_b, alu_op}), 0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
    chk({tag, "_resp"}, 32'({resp_id, resp_out, resp_zero, resp_carry, resp_err}), 0);
  endtask
  task automatic do_reset();
    req_valid = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    sample();
    chk_reset_vals("rst");
    advance();
  endtask
  task automatic rnd_drive();
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !acc_mask[i]) begin
        if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        req_valid[i] = 1'b1;
        req_a[8*i +: 8] = 8'($urandom);
        req_b[8*i +: 8] = 8'($urandom);
        req_op[4*i +: 4] = 4'($urandom);
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    resp_ready = $urandom_range(0, 9) < 7;
    reset = $urandom_range(0, 199) == 0;
  endtask
  initial begin
    int gid[5], gcy[5], ng, hs;
    bit saw;
    n_cmp = 0;
    n_bad = 0;
    busy = 0;
    wait_c = 0;
    last = NREQ - 1;
    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    resp_ready = 1'b1;
    do_reset();
    // single add with carry-out and zero result
    req_valid = 4'b0001;
    req_a[7:0] = 8'hFF;
    req_b[7:0] = 8'h01;
    req_op[3:0] = 4'h1;
    step();
    req_valid = '0;
    step();
    sample();
    chk("t1_valid", 32'(resp_valid), 1);
    chk("t1_out", 32'(resp_out), 0);
    chk("t1_carry", 32'(resp_carry), 1);
    chk("t1_zero", 32'(resp_zero), 1);
    chk("t1_id", 32'(resp_id), 0);
    chk("t1_err", 32'(resp_err), 0);
    advance();
    step();
    // round-robin with all requesters pending
    do_reset();
    req_valid = '1;
    req_a = 32'h0403_0201;
    req_b = 32'h1111_1111;
    req_op = 16'h1111;
    ng = 0;
    for (int k = 0; k < 5; k++) begin
      gid[k] = -1;
      gcy[k] = -1;
    end
    for (int c = 0; c < 16; c++) begin
      sample();
      if (req_ready != '0 && ng < 5) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid[ng] = i;
        gcy[ng] = c;
        ng++;
      end
      advance();
    end
    for (int k = 0; k < 5; k++) begin
      chk("rr_id", gid[k], k % NREQ);
      chk("rr_cycle", gcy[k], 3 * k);
    end
    req_valid = '0;
    repeat (3) step();
    // backpressure on a borrowing subtract with requester 1 waiting
    req_valid = 4'b0100;
    req_a[23:16] = 8'h00;
    req_b[23:16] = 8'h01;
    req_op[11:8] = 4'h2;
    resp_ready = 1'b0;
    step();
    req_valid = 4'b0010;
    req_a[15:8] = 8'h12;
    req_b[15:8] = 8'h34;
    req_op[7:4] = 4'h5;
    step();
    repeat (5) begin
      sample();
      chk("bp_valid", 32'(resp_valid), 1);
      chk("bp_out", 32'(resp_out), 32'hFF);
      chk("bp_carry", 32'(resp_carry), 1);
      chk("bp_ready", 32'(req_ready), 0);
      advance();
    end
    resp_ready = 1'b1;
    step();
    sample();
    chk("bp_next", 32'(req_ready), 32'b0010);
    advance();
    req_valid = '0;
    repeat (3) step();
    // illegal opcode
    req_valid = 4'b1000;
    req_a[31:24] = 8'h55;
    req_b[31:24] = 8'hAA;
    req_op[15:12] = 4'hD;
    step();
    req_valid = '0;
    step();
    sample();
    chk("ill_err", 32'(resp_err), 1);
    chk("ill_out", 32'(resp_out), 0);
    chk("ill_zero", 32'(resp_zero), 1);
    chk("ill_carry", 32'(resp_carry), 0);
    chk("ill_id", 32'(resp_id), 3);
    advance();
    step();
    // reset while executing
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    sample();
    chk_reset_vals("midrst");
    advance();
    req_valid = 4'b0011;
    sample();
    chk("midrst_grant", 32'(req_ready), 32'b0001);
    advance();
    req_valid = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      step();
      if (acc_mask[1]) req_valid[1] = 1'b0;
    end
    // request raised and withdrawn while a response is stalled
    resp_ready = 1'b0;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    step();
    saw = 0;
    hs = 0;
    req_valid = 4'b0010;
    sample();
    saw |= req_ready[1];
    advance();
    req_valid = '0;
    repeat (3) begin
      sample();
      saw |= req_ready[1];
      advance();
    end
    resp_ready = 1'b1;
    repeat (6) begin
      sample();
      saw |= req_ready[1];
      if (resp_valid && resp_ready) hs++;
      advance();
    end
    chk("wd_grant", 32'(saw), 0);
    chk("wd_resps", hs, 1);
    // randomized traffic
    repeat (3000) begin
      step();
      rnd_drive();
    end
    reset = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
